// File: rtl/icache_pkg.sv
// Shared icache constants: default geometry, derived widths and FSM state encodings.
// Optional statistics counters are enabled in the top level by defining ICACHE_STATS_EN.
package icache_pkg;
   localparam int DEF_INDEX_BITS = 3;
   localparam int DEF_ADDR_BITS  = 10;
   localparam int OFFSET_BITS    = 2;
   localparam int BLOCK_BITS     = 4;
   localparam int DEF_TAG_BITS   = DEF_ADDR_BITS - BLOCK_BITS - DEF_INDEX_BITS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   function automatic int tag_bits(input int addr_bits, input int index_bits);
      return addr_bits - BLOCK_BITS - index_bits;
   endfunction
endpackage

// File: rtl/icache_ctrl.sv
// Miss FSM: latches the block address on a miss, runs the memory handshake and
// holds the returned block in a fill register until the UPDATE cycle writes it.
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hit,
   input  logic [ADDR_BITS-5:0] blk_addr,
   input  logic                 mem_busywait,
   input  logic [127:0]         mem_readdata,
   output logic                 busywait,
   output logic                 mem_read,
   output logic [ADDR_BITS-5:0] mem_address,
   output logic [ADDR_BITS-5:0] req_addr,
   output logic [127:0]         fill_data,
   output logic                 fill_we,
   output logic                 idle_hit,
   output logic                 miss_start
);
   logic [1:0] state;
   logic       idle;

   // Reset masks every output so a response arriving mid-reset is never acted on.
   assign idle        = !reset && (state == ST_IDLE);
   assign idle_hit    = idle && hit;
   assign miss_start  = idle && !hit;
   assign busywait    = !reset && ((state != ST_IDLE) || !hit);
   assign mem_read    = !reset && (state == ST_FETCH);
   assign mem_address = mem_read ? req_addr : '0;
   assign fill_we     = !reset && (state == ST_UPDATE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_addr  <= '0;
         fill_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!hit) begin
                  req_addr <= blk_addr;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (!mem_busywait) begin
                  fill_data <= mem_readdata;
                  state     <= ST_UPDATE;
               end
            end
            ST_UPDATE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: tag/valid/data arrays and word mux, zero-cycle hits.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [31:0]          PC,
   output logic [31:0]          INSTRUCTION,
   output logic                 BUSYWAIT,
   output logic                 MEM_READ,
   output logic [ADDR_BITS-5:0] MEM_ADDRESS,
   input  logic [127:0]         MEM_READDATA,
   input  logic                 MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]          HIT_COUNT,
   output logic [15:0]          MISS_COUNT
`endif
);
   localparam int TAG_BITS = tag_bits(ADDR_BITS, INDEX_BITS);
   localparam int LINES    = 1 << INDEX_BITS;

   logic [ADDR_BITS-5:0]   blk_addr, req_addr;
   logic [INDEX_BITS-1:0]  index, fill_index;
   logic [TAG_BITS-1:0]    tag, fill_tag;
   logic [OFFSET_BITS-1:0] offset;
   logic [127:0]           data_arr [LINES];
   logic [TAG_BITS-1:0]    tag_arr  [LINES];
   logic [LINES-1:0]       valid;
   logic [127:0]           line, fill_data;
   logic [31:0]            word, last_instr;
   logic                   hit, fill_we, idle_hit, miss_start;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};
   assign blk_addr   = PC[ADDR_BITS-1:4];
   assign offset     = PC[3:2];
   assign index      = blk_addr[INDEX_BITS-1:0];
   assign tag        = blk_addr[ADDR_BITS-5:INDEX_BITS];
   assign fill_index = req_addr[INDEX_BITS-1:0];
   assign fill_tag   = req_addr[ADDR_BITS-5:INDEX_BITS];

   assign hit  = valid[index] && (tag_arr[index] == tag);
   assign line = data_arr[index];

   always_comb begin
      case (offset)
         2'd0:    word = line[31:0];
         2'd1:    word = line[63:32];
         2'd2:    word = line[95:64];
         default: word = line[127:96];
      endcase
   end

   // Outside a hit cycle the CPU keeps seeing the last word it was given.
   assign INSTRUCTION = idle_hit ? word : (RESET ? 32'd0 : last_instr);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid      <= '0;
         last_instr <= '0;
      end else begin
         if (fill_we)  valid[fill_index] <= 1'b1;
         if (idle_hit) last_instr        <= word;
      end
   end

   always_ff @(posedge CLK) begin
      if (fill_we) begin
         data_arr[fill_index] <= fill_data;
         tag_arr[fill_index]  <= fill_tag;
      end
   end

   icache_ctrl #(.ADDR_BITS(ADDR_BITS)) u_ctrl (
      .clk          (CLK),
      .reset        (RESET),
      .hit          (hit),
      .blk_addr     (blk_addr),
      .mem_busywait (MEM_BUSYWAIT),
      .mem_readdata (MEM_READDATA),
      .busywait     (BUSYWAIT),
      .mem_read     (MEM_READ),
      .mem_address  (MEM_ADDRESS),
      .req_addr     (req_addr),
      .fill_data    (fill_data),
      .fill_we      (fill_we),
      .idle_hit     (idle_hit),
      .miss_start   (miss_start)
   );

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         HIT_COUNT  <= '0;
         MISS_COUNT <= '0;
      end else begin
         if (idle_hit && (HIT_COUNT != 16'hFFFF))    HIT_COUNT  <= HIT_COUNT + 16'd1;
         if (miss_start && (MISS_COUNT != 16'hFFFF)) MISS_COUNT <= MISS_COUNT + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache.sv
// Bench for icache: behavioural block memory with programmable latency, hit vectors
// checked through an expected-word queue, hand-written miss / reset / PC-change sequences.
module tb_icache;
   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  PC;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT, MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
   logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat   = 4;
   int          mcnt  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;
   vec_t vecs[3];

   icache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
      ,
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mword(input logic [5:0] blk, input logic [1:0] w);
      return {16'hC0DE, 2'b00, blk, 6'b000000, w};
   endfunction

   always_comb MEM_READDATA = {mword(MEM_ADDRESS, 2'd3), mword(MEM_ADDRESS, 2'd2),
                               mword(MEM_ADDRESS, 2'd1), mword(MEM_ADDRESS, 2'd0)};

   // Memory stays busy for `lat` cycles of each read request, then returns data.
   always @(posedge CLK) mcnt <= MEM_READ ? mcnt + 1 : 0;
   assign MEM_BUSYWAIT = MEM_READ && (mcnt < lat);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_hit(input string name, input logic [31:0] pc, input logic [31:0] exp);
      logic [31:0] want;
      PC = pc;
      exp_q.push_back(exp);
      @(negedge CLK);
      want = exp_q.pop_front();
      chk({name, "_busy"}, 32'(BUSYWAIT), 32'd0);
      chk({name, "_rd"}, 32'(MEM_READ), 32'd0);
      chk({name, "_instr"}, INSTRUCTION, want);
      step();
   endtask

   task automatic miss_run(input string name, input logic [31:0] pc, input logic [5:0] exp_addr,
                           input int exp_cycles, input logic [31:0] hold);
      int          n = 0;
      bit          done = 0, rd_seen = 0, addr_ok = 1, hold_ok = 1;
      logic [31:0] want;
      PC = pc;
      exp_q.push_back(mword(exp_addr, pc[3:2]));
      @(negedge CLK);
      chk({name, "_busy_now"}, 32'(BUSYWAIT), 32'd1);
      for (int i = 0; i < 200 && !done; i++) begin
         if (!BUSYWAIT) done = 1;
         else begin
            n++;
            if (MEM_READ) begin
               rd_seen = 1;
               if (MEM_ADDRESS !== exp_addr) addr_ok = 0;
            end else if (MEM_ADDRESS !== 6'd0) addr_ok = 0;
            if (INSTRUCTION !== hold) hold_ok = 0;
            step();
            @(negedge CLK);
         end
      end
      want = exp_q.pop_front();
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
      chk({name, "_rd_seen"}, 32'(rd_seen), 32'd1);
      chk({name, "_addr_ok"}, 32'(addr_ok), 32'd1);
      chk({name, "_hold_ok"}, 32'(hold_ok), 32'd1);
      chk({name, "_instr"}, INSTRUCTION, want);
      step();
   endtask

   initial begin
      int rd_cnt;
      bit addr_ok;
      vecs[0] = '{32'h004, mword(6'd0, 2'd1)};
      vecs[1] = '{32'h008, mword(6'd0, 2'd2)};
      vecs[2] = '{32'h00C, mword(6'd0, 2'd3)};

      RESET = 1'b1;
      PC    = 32'd0;
      lat   = 4;
      step();
      @(negedge CLK);
      chk("rst_busy", 32'(BUSYWAIT), 32'd0);
      chk("rst_rd", 32'(MEM_READ), 32'd0);
      chk("rst_addr", 32'(MEM_ADDRESS), 32'd0);
      chk("rst_instr", INSTRUCTION, 32'd0);
      step();
      RESET = 1'b0;

      miss_run("first_miss", 32'h000, 6'h00, 7, 32'd0);
      for (int i = 0; i < 3; i++) check_hit($sformatf("hit%0d", i), vecs[i].pc, vecs[i].instr);
`ifdef ICACHE_STATS_EN
      chk("stat_hits", 32'(HIT_COUNT), 32'd4);
      chk("stat_miss", 32'(MISS_COUNT), 32'd1);
`endif

      lat = 2;
      miss_run("conflict", 32'h080, 6'h08, 5, mword(6'd0, 2'd3));
      miss_run("refill0", 32'h000, 6'h00, 5, mword(6'd8, 2'd0));

      // Reset pulse in the second FETCH cycle of a miss.
      lat = 4;
      PC  = 32'h030;
      step();
      step();
      RESET = 1'b1;
      @(negedge CLK);
      chk("midrst_rd", 32'(MEM_READ), 32'd0);
      chk("midrst_busy", 32'(BUSYWAIT), 32'd0);
      chk("midrst_instr", INSTRUCTION, 32'd0);
      step();
      RESET = 1'b0;
      miss_run("postrst_30", 32'h030, 6'h03, 7, 32'd0);
      miss_run("postrst_0", 32'h000, 6'h00, 7, mword(6'd3, 2'd0));

      // PC moves during FETCH; the fill must stay on the latched block.
      PC = 32'h010;
      @(negedge CLK);
      chk("pcchg_busy", 32'(BUSYWAIT), 32'd1);
      step();
      PC      = 32'h020;
      rd_cnt  = 0;
      addr_ok = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (MEM_READ) begin
            rd_cnt++;
            if (MEM_ADDRESS !== 6'h01) addr_ok = 0;
         end
         step();
      end
      chk("pcchg_rd_cycles", 32'(rd_cnt), 32'd5);
      chk("pcchg_addr_ok", 32'(addr_ok), 32'd1);
      @(negedge CLK);
      chk("pcchg_next_busy", 32'(BUSYWAIT), 32'd1);
      chk("pcchg_next_rd", 32'(MEM_READ), 32'd0);
      step();
      @(negedge CLK);
      chk("pcchg_addr2", 32'(MEM_ADDRESS), 32'h02);
      for (int i = 0; i < 100 && BUSYWAIT; i++) begin
         step();
         @(negedge CLK);
      end
      chk("pcchg_fill2_busy", 32'(BUSYWAIT), 32'd0);
      chk("pcchg_fill2_instr", INSTRUCTION, mword(6'd2, 2'd0));
      step();
      check_hit("pcchg_line1", 32'h010, mword(6'd1, 2'd0));
      check_hit("pcchg_line2", 32'h02C, mword(6'd2, 2'd3));
`ifdef ICACHE_STATS_EN
      chk("stat_miss_end", 32'(MISS_COUNT), 32'd4);
      chk("stat_hits_end", 32'(HIT_COUNT), 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
